// File: rtl/ddr3_csr_bank.sv
// ddr3_csr_bank: CSR block for a DDR3 frame-buffer controller.
// Holds per-channel buffer offsets and full/overflow flags, a small
// test-access engine (address, write data, command FSM), and read-back
// of test read data. Define DDR3_CSR_IRQ_EN to build the interrupt
// status/enable registers; without it irq is tied low.
module ddr3_csr_bank #(
    parameter int NUM_BUF    = 2,
    parameter int OFFSET_W   = 26,
    parameter int TEST_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       csr_read,
    input  logic                       csr_write,
    input  logic [7:0]                 csr_addr,
    input  logic [31:0]                csr_wr_data,
    output logic [31:0]                csr_rd_data,
    output logic [NUM_BUF*OFFSET_W-1:0] buf_offset,
    output logic [NUM_BUF-1:0]         buf_empty,
    input  logic [NUM_BUF-1:0]         buf_clear,
    output logic [31:0]                test_addr,
    output logic [32*TEST_WORDS-1:0]   test_wr_data,
    output logic                       test_wr,
    output logic                       test_rd,
    input  logic [32*TEST_WORDS-1:0]   test_rd_data,
    input  logic                       wr_finish,
    input  logic                       rd_finish,
    output logic                       irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2
    } test_state_t;

    localparam logic [31:0] MAGIC = 32'hB00BB00C;

    logic [OFFSET_W-1:0] offset_q [NUM_BUF];
    logic [31:0]         test_wd_q [TEST_WORDS];
    logic [31:0]         test_addr_q;
    logic [NUM_BUF-1:0]  full, full_nxt, ovf, ovf_nxt;
    test_state_t         state, state_nxt;
    logic                done, done_nxt, cmd_err, cmd_err_nxt;
    logic                test_wr_nxt, test_rd_nxt;
    logic                ctrl_wr;
    logic [31:0]         rd_mux;

    assign ctrl_wr   = csr_write && (csr_addr == 8'h20);
    assign buf_empty = ~full;
    assign test_addr = test_addr_q;

    // Flatten the per-channel and per-word register arrays onto the output buses
    always_comb begin
        for (int i = 0; i < NUM_BUF; i++) buf_offset[i*OFFSET_W +: OFFSET_W] = offset_q[i];
        for (int k = 0; k < TEST_WORDS; k++) test_wr_data[k*32 +: 32] = test_wd_q[k];
    end

    // Plain R/W registers: offsets, test address and test write data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUF; i++) offset_q[i] <= '0;
            for (int k = 0; k < TEST_WORDS; k++) test_wd_q[k] <= '0;
            test_addr_q <= '0;
        end else if (csr_write) begin
            for (int i = 0; i < NUM_BUF; i++)
                if (csr_addr == 8'(i)) offset_q[i] <= csr_wr_data[OFFSET_W-1:0];
            for (int k = 0; k < TEST_WORDS; k++)
                if (csr_addr == 8'(17 + k)) test_wd_q[k] <= csr_wr_data;
            if (csr_addr == 8'h10) test_addr_q <= csr_wr_data;
        end
    end

    // Full/overflow next state: CSR set beats consumer clear; overflow set beats overflow clear
    always_comb begin
        full_nxt = full;
        ovf_nxt  = ovf;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (csr_write && (csr_addr == 8'(8 + i)) && csr_wr_data[0]) begin
                full_nxt[i] = 1'b1;
                if (full[i]) ovf_nxt[i] = 1'b1;
                else if (csr_wr_data[1]) ovf_nxt[i] = 1'b0;
            end else begin
                if (buf_clear[i]) full_nxt[i] = 1'b0;
                if (csr_write && (csr_addr == 8'(8 + i)) && csr_wr_data[1]) ovf_nxt[i] = 1'b0;
            end
        end
    end

    // Channel flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= '0;
            ovf  <= '0;
        end else begin
            full <= full_nxt;
            ovf  <= ovf_nxt;
        end
    end

    // Test FSM next state: a control write first clears done/cmd_err, then launches or rejects a command
    always_comb begin
        state_nxt   = state;
        test_wr_nxt = 1'b0;
        test_rd_nxt = 1'b0;
        done_nxt    = done;
        cmd_err_nxt = cmd_err;
        if (ctrl_wr) begin
            done_nxt    = 1'b0;
            cmd_err_nxt = 1'b0;
        end
        case (state)
            IDLE: begin
                if (ctrl_wr && csr_wr_data[0]) begin
                    test_wr_nxt = 1'b1;
                    state_nxt   = WR_BUSY;
                end else if (ctrl_wr && csr_wr_data[1]) begin
                    test_rd_nxt = 1'b1;
                    state_nxt   = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (ctrl_wr && (csr_wr_data[1:0] != 2'b00)) cmd_err_nxt = 1'b1;
                if (wr_finish) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            RD_BUSY: begin
                if (ctrl_wr && (csr_wr_data[1:0] != 2'b00)) cmd_err_nxt = 1'b1;
                if (rd_finish) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Test FSM state register with registered single-cycle command pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            test_wr <= 1'b0;
            test_rd <= 1'b0;
            done    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            test_wr <= test_wr_nxt;
            test_rd <= test_rd_nxt;
            done    <= done_nxt;
            cmd_err <= cmd_err_nxt;
        end
    end

`ifdef DDR3_CSR_IRQ_EN
    logic [8:0] irq_status, irq_enable, hw_set;

    // Interrupt sources: channel drained (full falling) and test command completion
    always_comb begin
        hw_set = '0;
        hw_set[NUM_BUF-1:0] = full & ~full_nxt;
        hw_set[8] = done_nxt & ~done;
    end

    // Status is W1C with hardware sets taking precedence; enable is plain R/W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_status <= '0;
            irq_enable <= '0;
        end else begin
            if (csr_write && (csr_addr == 8'h30))
                irq_status <= (irq_status & ~csr_wr_data[8:0]) | hw_set;
            else
                irq_status <= irq_status | hw_set;
            if (csr_write && (csr_addr == 8'h31)) irq_enable <= csr_wr_data[8:0];
        end
    end

    assign irq = |(irq_status & irq_enable);
`else
    assign irq = 1'b0;
`endif

    // Read decode; unmapped addresses and out-of-range indices fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (csr_addr == 8'(i))     rd_mux = 32'(offset_q[i]);
            if (csr_addr == 8'(8 + i)) rd_mux = {30'b0, ovf[i], full[i]};
        end
        for (int k = 0; k < TEST_WORDS; k++) begin
            if (csr_addr == 8'(17 + k)) rd_mux = test_wd_q[k];
            if (csr_addr == 8'(33 + k)) rd_mux = test_rd_data[k*32 +: 32];
        end
        if (csr_addr == 8'h10) rd_mux = test_addr_q;
        if (csr_addr == 8'h20)
            rd_mux = {28'b0, cmd_err, done, state == RD_BUSY, state == WR_BUSY};
`ifdef DDR3_CSR_IRQ_EN
        if (csr_addr == 8'h30) rd_mux = 32'(irq_status);
        if (csr_addr == 8'h31) rd_mux = 32'(irq_enable);
`endif
        if (csr_addr == 8'h3F) rd_mux = MAGIC;
    end

    // Registered read data, held while no read is requested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      csr_rd_data <= '0;
        else if (csr_read) csr_rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_ddr3_csr_bank.sv
// tb_ddr3_csr_bank: directed self-checking bench for ddr3_csr_bank
// (default parameters; expectations follow DDR3_CSR_IRQ_EN if defined).
module tb_ddr3_csr_bank;

`ifdef DDR3_CSR_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         csr_read = 1'b0;
    logic         csr_write = 1'b0;
    logic [7:0]   csr_addr = '0;
    logic [31:0]  csr_wr_data = '0;
    logic [31:0]  csr_rd_data;
    logic [51:0]  buf_offset;
    logic [1:0]   buf_empty;
    logic [1:0]   buf_clear = '0;
    logic [31:0]  test_addr;
    logic [127:0] test_wr_data;
    logic         test_wr, test_rd;
    logic [127:0] test_rd_data = '0;
    logic         wr_finish = 1'b0;
    logic         rd_finish = 1'b0;
    logic         irq;

    int check_count = 0;
    int pass_count  = 0;
    int wr_pulses   = 0;
    int rd_pulses   = 0;
    int wr_base, rd_base;

    ddr3_csr_bank dut (
        .clk(clk), .reset_n(reset_n),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_addr(csr_addr), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
        .buf_offset(buf_offset), .buf_empty(buf_empty), .buf_clear(buf_clear),
        .test_addr(test_addr), .test_wr_data(test_wr_data),
        .test_wr(test_wr), .test_rd(test_rd), .test_rd_data(test_rd_data),
        .wr_finish(wr_finish), .rd_finish(rd_finish), .irq(irq)
    );

    always #5 clk = ~clk;

    // Count cycles in which each command pulse is high
    always @(negedge clk) begin
        if (test_wr) wr_pulses++;
        if (test_rd) rd_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // One-cycle CSR access starting and ending on a falling edge; read data is valid on return
    task automatic applyStimulus(input bit is_write, input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        csr_addr    = addr;
        csr_wr_data = data;
        csr_write   = is_write;
        csr_read    = ~is_write;
        @(negedge clk);
        csr_write = 1'b0;
        csr_read  = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        buf_clear = 2'b01;
        @(negedge clk);
        buf_clear = 2'b00;
    endtask

    initial begin
        $display("[TB] starting ddr3_csr_bank bench, irq build = %0d", IRQ_BUILD);
        #12;
        checkOutput("reset_rd_data", csr_rd_data, 32'h0);
        checkOutput("reset_empty", {30'b0, buf_empty}, 32'h3);
        checkOutput("reset_pulses", {30'b0, test_wr, test_rd}, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Offsets: only OFFSET_W bits are kept
        applyStimulus(1'b1, 8'h00, 32'hFFFFFFFF);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("offset0_rd", csr_rd_data, 32'h03FFFFFF);
        checkOutput("offset0_port", {6'b0, buf_offset[25:0]}, 32'h03FFFFFF);
        applyStimulus(1'b1, 8'h01, 32'h12345678);
        applyStimulus(1'b0, 8'h01, 32'h0);
        checkOutput("offset1_rd", csr_rd_data, 32'h02345678);
        checkOutput("offset1_port", {6'b0, buf_offset[51:26]}, 32'h02345678);
        applyStimulus(1'b1, 8'h02, 32'hAAAAAAAA);
        applyStimulus(1'b0, 8'h02, 32'h0);
        checkOutput("offset2_absent", csr_rd_data, 32'h0);

        // Constant, unmapped address, and read-data hold
        applyStimulus(1'b0, 8'h3F, 32'h0);
        checkOutput("magic", csr_rd_data, 32'hB00BB00C);
        @(negedge clk);
        csr_addr = 8'h00;
        @(negedge clk);
        checkOutput("rd_hold", csr_rd_data, 32'hB00BB00C);
        applyStimulus(1'b0, 8'h3E, 32'h0);
        checkOutput("unmapped", csr_rd_data, 32'h0);

        // Test address, write data words and read data passthrough
        applyStimulus(1'b1, 8'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 8'h10, 32'h0);
        checkOutput("test_addr_rd", csr_rd_data, 32'hDEADBEEF);
        checkOutput("test_addr_port", test_addr, 32'hDEADBEEF);
        applyStimulus(1'b1, 8'h12, 32'hCAFE0001);
        applyStimulus(1'b0, 8'h12, 32'h0);
        checkOutput("twd1_rd", csr_rd_data, 32'hCAFE0001);
        checkOutput("twd1_port", test_wr_data[63:32], 32'hCAFE0001);
        applyStimulus(1'b1, 8'h15, 32'h55555555);
        applyStimulus(1'b0, 8'h15, 32'h0);
        checkOutput("twd4_absent", csr_rd_data, 32'h0);
        test_rd_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        applyStimulus(1'b0, 8'h22, 32'h0);
        checkOutput("trd1", csr_rd_data, 32'h22222222);
        applyStimulus(1'b0, 8'h24, 32'h0);
        checkOutput("trd3", csr_rd_data, 32'h44444444);
        applyStimulus(1'b0, 8'h25, 32'h0);
        checkOutput("trd4_absent", csr_rd_data, 32'h0);

        // Full / overflow flags on channel 0
        applyStimulus(1'b1, 8'h08, 32'h1);
        checkOutput("set_full", {30'b0, buf_empty}, 32'h2);
        applyStimulus(1'b1, 8'h08, 32'h1);
        applyStimulus(1'b0, 8'h08, 32'h0);
        checkOutput("ovf_set", csr_rd_data, 32'h3);
        pulseClear();
        checkOutput("drained", {30'b0, buf_empty}, 32'h3);
        applyStimulus(1'b0, 8'h08, 32'h0);
        checkOutput("ovf_sticky", csr_rd_data, 32'h2);
        applyStimulus(1'b1, 8'h08, 32'h2);
        applyStimulus(1'b0, 8'h08, 32'h0);
        checkOutput("ovf_cleared", csr_rd_data, 32'h0);
        // CSR set and consumer clear in the same cycle: set wins
        @(negedge clk);
        buf_clear = 2'b01; csr_write = 1'b1; csr_addr = 8'h08; csr_wr_data = 32'h1;
        @(negedge clk);
        buf_clear = 2'b00; csr_write = 1'b0;
        checkOutput("set_beats_clear", {30'b0, buf_empty}, 32'h2);
        // Overflow set and clear in the same write: set wins
        applyStimulus(1'b1, 8'h08, 32'h3);
        applyStimulus(1'b0, 8'h08, 32'h0);
        checkOutput("ovf_set_beats_clr", csr_rd_data, 32'h3);
        applyStimulus(1'b1, 8'h08, 32'h2);
        pulseClear();
        applyStimulus(1'b0, 8'h08, 32'h0);
        checkOutput("chan0_idle", csr_rd_data, 32'h0);
        applyStimulus(1'b0, 8'h0A, 32'h0);
        checkOutput("chan2_absent", csr_rd_data, 32'h0);

        // Test FSM: write command, dropped command, completion
        wr_base = wr_pulses; rd_base = rd_pulses;
        applyStimulus(1'b1, 8'h20, 32'h3);
        @(negedge clk);
        checkOutput("wr_pulse_count", 32'(wr_pulses - wr_base), 32'd1);
        checkOutput("rd_pulse_none", 32'(rd_pulses - rd_base), 32'd0);
        applyStimulus(1'b0, 8'h20, 32'h0);
        checkOutput("wr_busy", csr_rd_data, 32'h1);
        applyStimulus(1'b1, 8'h20, 32'h2);
        @(negedge clk);
        checkOutput("dropped_no_pulse", 32'((wr_pulses - wr_base) + (rd_pulses - rd_base)), 32'd1);
        applyStimulus(1'b0, 8'h20, 32'h0);
        checkOutput("cmd_err", csr_rd_data, 32'h9);
        @(negedge clk); wr_finish = 1'b1;
        @(negedge clk); wr_finish = 1'b0;
        applyStimulus(1'b0, 8'h20, 32'h0);
        // cmd_err stays set from the dropped command; done now set, busy cleared
        checkOutput("wr_done", csr_rd_data, 32'hC);

        // Read command, mismatched finish, reset mid-command
        rd_base = rd_pulses;
        applyStimulus(1'b1, 8'h20, 32'h2);
        @(negedge clk);
        checkOutput("rd_pulse_count", 32'(rd_pulses - rd_base), 32'd1);
        @(negedge clk); wr_finish = 1'b1;
        @(negedge clk); wr_finish = 1'b0;
        applyStimulus(1'b0, 8'h20, 32'h0);
        checkOutput("rd_busy_hold", csr_rd_data, 32'h2);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        checkOutput("mid_reset_rd_data", csr_rd_data, 32'h0);
        checkOutput("mid_reset_pulses", {30'b0, test_wr, test_rd}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); rd_finish = 1'b1;
        @(negedge clk); rd_finish = 1'b0;
        applyStimulus(1'b0, 8'h20, 32'h0);
        checkOutput("after_reset_ctrl", csr_rd_data, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0);
        checkOutput("after_reset_offset", csr_rd_data, 32'h0);

        // Interrupts
        applyStimulus(1'b1, 8'h31, 32'h1);
        applyStimulus(1'b0, 8'h31, 32'h0);
        checkOutput("irq_enable_rd", csr_rd_data, IRQ_BUILD ? 32'h1 : 32'h0);
        applyStimulus(1'b1, 8'h08, 32'h1);
        checkOutput("irq_before_fall", {31'b0, irq}, 32'h0);
        pulseClear();
        checkOutput("irq_on_fall", {31'b0, irq}, {31'b0, IRQ_BUILD});
        applyStimulus(1'b1, 8'h30, 32'h1);
        checkOutput("irq_w1c", {31'b0, irq}, 32'h0);
        applyStimulus(1'b1, 8'h08, 32'h1);
        @(negedge clk);
        buf_clear = 2'b01; csr_write = 1'b1; csr_addr = 8'h30; csr_wr_data = 32'h1;
        @(negedge clk);
        buf_clear = 2'b00; csr_write = 1'b0;
        checkOutput("irq_set_beats_w1c", {31'b0, irq}, {31'b0, IRQ_BUILD});
        applyStimulus(1'b0, 8'h30, 32'h0);
        checkOutput("irq_status_rd", csr_rd_data, IRQ_BUILD ? 32'h1 : 32'h0);
        applyStimulus(1'b0, 8'h3F, 32'h0);
        checkOutput("magic_end", csr_rd_data, 32'hB00BB00C);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
